instr_encoder_jump: RTL and testbench

INSTR_ENCODER_JUMP -- requirements
Module: instr_encoder_jump

---
 rtl/instr_encoder_jump.sv | 141 ++++++++++++++
 tb/tb_instr_encoder_jump.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_jump.sv
// instr_encoder_jump
//   Turns a (rd, byte offset) jump request into RV32I machine code.
//   Near offsets (aligned, within the JAL +-1 MiB reach) become one JAL word.
//   Far offsets (or every request when FORCE_FAR=1) become an AUIPC/JALR pair
//   through a temporary register: rd itself, or TMP_REG when rd is x0.
//   Misaligned offsets are rejected with a one-cycle err pulse.
//
// Parameters
//   FORCE_FAR  1 forces the two-word form for every valid request
//   TMP_REG    scratch register for the far form when rd == 0
//
// Ports
//   clk        clock
//   rst_n      asynchronous active-low reset
//   in_valid   request present            in_ready   block can accept (IDLE only)
//   rd         link/destination register  offset     signed byte offset from jump PC
//   out_valid  out_instr holds a word     out_ready  consumer takes the word
//   out_instr  encoded instruction        out_last   word ends the sequence
//   err        one-cycle pulse on a rejected misaligned offset

module instr_encoder_jump #(
  parameter bit FORCE_FAR = 1'b0,
  parameter int TMP_REG   = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  rd,
  input  logic [31:0] offset,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_last,
  output logic        err
);

  localparam logic [4:0] TMP_RD = 5'(TMP_REG);

  typedef enum logic [1:0] {
    IDLE,
    EMIT_JAL,
    EMIT_AUIPC,
    EMIT_JALR
  } state_t;

  state_t      state;
  logic [4:0]  rd_q;
  logic [31:0] off_q;

  logic        accept;
  logic        is_near;
  logic [4:0]  src_rd;
  logic [4:0]  src_tmp;
  logic [31:0] src_off;
  logic [19:0] hi;
  logic [11:0] lo;
  logic [31:0] jal_word;
  logic [31:0] auipc_word;
  logic [31:0] jalr_word;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;

  // Words are built from the live inputs on the accepting edge and from the
  // captured copies afterwards, so every word of a sequence sees one request.
  assign src_rd  = accept ? rd     : rd_q;
  assign src_off = accept ? offset : off_q;
  assign src_tmp = (src_rd == 5'd0) ? TMP_RD : src_rd;

  // Aligned offsets inside the JAL reach; anything else needs AUIPC/JALR.
  assign is_near = !FORCE_FAR &&
                   ($signed(offset) >= -32'sd1048576) &&
                   ($signed(offset) <=  32'sd1048574);

  // (off + 0x800) >> 12: adding 0x800 only carries into bit 12 when bit 11 is
  // set, which pre-compensates for JALR sign-extending a negative lo.
  assign hi = src_off[31:12] + {19'd0, src_off[11]};
  assign lo = src_off[11:0];

  assign jal_word   = {src_off[20], src_off[10:1], src_off[11], src_off[19:12],
                       src_rd, 7'b1101111};
  assign auipc_word = {hi, src_tmp, 7'b0010111};
  assign jalr_word  = {lo, src_tmp, 3'b000, src_rd, 7'b1100111};

  // Control FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rd_q      <= 5'd0;
      off_q     <= 32'd0;
      out_valid <= 1'b0;
      out_instr <= 32'd0;
      out_last  <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            rd_q  <= rd;
            off_q <= offset;
            if (offset[0]) begin
              err <= 1'b1;
            end else if (is_near) begin
              state     <= EMIT_JAL;
              out_valid <= 1'b1;
              out_instr <= jal_word;
              out_last  <= 1'b1;
            end else begin
              state     <= EMIT_AUIPC;
              out_valid <= 1'b1;
              out_instr <= auipc_word;
              out_last  <= 1'b0;
            end
          end
        end
        EMIT_AUIPC: begin
          if (out_ready) begin
            state     <= EMIT_JALR;
            out_instr <= jalr_word;
            out_last  <= 1'b1;
          end
        end
        EMIT_JAL, EMIT_JALR: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_jump.sv
// tb_instr_encoder_jump
//   Directed, self-checking bench for instr_encoder_jump with default
//   parameters. Each scenario task drives its stimulus and compares the DUT
//   outputs against hand-computed instruction words.

module tb_instr_encoder_jump;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  rd;
  logic [31:0] offset;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_last;
  logic        err;

  int n_vec;
  int n_err;

  instr_encoder_jump dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rd        (rd),
    .offset    (offset),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_last  (out_last),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and land just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for exactly one edge.
  task automatic send_req(input logic [4:0] r, input logic [31:0] off);
    in_valid = 1'b1;
    rd       = r;
    offset   = off;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    rd        = 5'd0;
    offset    = 32'd0;
    out_ready = 1'b1;
    #2;
    n_vec++;
    if ({out_valid, out_last, err} !== 3'b000 || out_instr !== 32'h0) begin
      n_err++;
      $display("[TB] FAIL reset_outputs: got v=%b l=%b e=%b instr=%h, expected 0 0 0 00000000",
               out_valid, out_last, err, out_instr);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL reset_release: got in_ready=%b out_valid=%b, expected 1 0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_near(input string name, input logic [4:0] r,
                           input logic [31:0] off, input logic [31:0] exp_word);
    out_ready = 1'b1;
    send_req(r, off);
    n_vec++;
    if (out_valid !== 1'b1 || out_instr !== exp_word || out_last !== 1'b1 || in_ready !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL %s_jal: got v=%b instr=%h last=%b rdy=%b, expected 1 %h 1 0",
               name, out_valid, out_instr, out_last, in_ready, exp_word);
    end
    step();
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL %s_idle: got v=%b rdy=%b, expected 0 1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_far(input string name, input logic [4:0] r, input logic [31:0] off,
                          input logic [31:0] exp_auipc, input logic [31:0] exp_jalr);
    out_ready = 1'b1;
    send_req(r, off);
    n_vec++;
    if (out_valid !== 1'b1 || out_instr !== exp_auipc || out_last !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL %s_auipc: got v=%b instr=%h last=%b, expected 1 %h 0",
               name, out_valid, out_instr, out_last, exp_auipc);
    end
    step();
    n_vec++;
    if (out_valid !== 1'b1 || out_instr !== exp_jalr || out_last !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL %s_jalr: got v=%b instr=%h last=%b, expected 1 %h 1",
               name, out_valid, out_instr, out_last, exp_jalr);
    end
    step();
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL %s_idle: got v=%b rdy=%b, expected 0 1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_misaligned();
    out_ready = 1'b1;
    send_req(5'd1, 32'h0000_0003);
    n_vec++;
    if (out_valid !== 1'b0 || err !== 1'b1 || in_ready !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL misaligned_pulse: got v=%b err=%b rdy=%b, expected 0 1 1",
               out_valid, err, in_ready);
    end
    step();
    n_vec++;
    if (out_valid !== 1'b0 || err !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL misaligned_after: got v=%b err=%b rdy=%b, expected 0 0 1",
               out_valid, err, in_ready);
    end
  endtask

  // in_valid held high: near requests land every other cycle, and inputs
  // changed mid-sequence must not leak into a far request's JALR word.
  task automatic test_back_to_back();
    logic exp_v;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    rd        = 5'd1;
    offset    = 32'h0000_0800;
    for (int i = 0; i < 4; i++) begin
      step();
      exp_v = (i % 2 == 0);
      n_vec++;
      if (out_valid !== exp_v) begin
        n_err++;
        $display("[TB] FAIL b2b_near_cycle%0d: got out_valid=%b, expected %b", i, out_valid, exp_v);
      end
    end
    in_valid = 1'b0;
    step();
    send_req(5'd1, 32'h0010_0000);
    in_valid = 1'b1;
    rd       = 5'd9;
    offset   = 32'h0000_0ABC;
    step();
    n_vec++;
    if (out_instr !== 32'h0000_80E7 || out_last !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL b2b_captured_jalr: got instr=%h last=%b, expected 000080e7 1",
               out_instr, out_last);
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_backpressure_reset();
    out_ready = 1'b0;
    send_req(5'd0, 32'h0020_0800);
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (out_valid !== 1'b1 || out_instr !== 32'h0020_1317 || out_last !== 1'b0 || in_ready !== 1'b0) begin
        n_err++;
        $display("[TB] FAIL stall_cycle%0d: got v=%b instr=%h last=%b rdy=%b, expected 1 00201317 0 0",
                 i, out_valid, out_instr, out_last, in_ready);
      end
      step();
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_last !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL async_reset: got v=%b instr=%h last=%b, expected 0 00000000 0",
               out_valid, out_instr, out_last);
    end
    step();
    out_ready = 1'b1;
    rst_n     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_err++;
        $display("[TB] FAIL post_reset_cycle%0d: got v=%b instr=%h rdy=%b, expected no word, rdy 1",
                 i, out_valid, out_instr, in_ready);
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_near("near_pos",  5'd1, 32'h0000_0800, 32'h0010_00EF);
    test_near("near_neg",  5'd0, 32'hFFFF_FFFC, 32'hFFDF_F06F);
    test_near("near_max",  5'd5, 32'h000F_FFFE, 32'h7FFF_F2EF);
    test_near("near_min",  5'd0, 32'hFFF0_0000, 32'h8000_006F);
    test_far("far_pos",    5'd1, 32'h0010_0000, 32'h0010_0097, 32'h0000_80E7);
    test_far("far_tmp",    5'd0, 32'h0020_0800, 32'h0020_1317, 32'h8003_0067);
    test_far("far_neg",    5'd2, 32'hFFEF_FFFE, 32'hFFF0_0117, 32'hFFE1_0167);
    test_misaligned();
    test_back_to_back();
    test_backpressure_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
